// File: rtl/pipeline_hazard_ctrl.sv
// Hazard unit for a 5-stage pipeline: forwarding, load-use stall, branch flush and data-memory wait FSM.
// Optional WAIT timeout with sticky ERR state is enabled by defining HAZARD_TIMEOUT_EN.
module pipeline_hazard_ctrl #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic [4:0]  Rs1E,
    input  logic [4:0]  Rs2E,
    input  logic [4:0]  RdE,
    input  logic [4:0]  RdM,
    input  logic [4:0]  RdW,
    input  logic        ResultSrcE0,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic        PCSrcE,
    input  logic        MemReqM,
    input  logic        mem_ack,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushW,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        mem_req,
    output logic [15:0] stall_cnt,
    output logic        mem_timeout,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1
`ifdef HAZARD_TIMEOUT_EN
        , S_ERR = 2'd2
`endif
    } state_t;

    state_t      r_state;
    logic [15:0] r_stall_cnt;
    logic        r_timeout;
    logic        w_lw_stall;
    logic        w_mem_stall;
    logic        w_in_err;
    logic        w_hold;

`ifdef HAZARD_TIMEOUT_EN
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    logic [CW-1:0] r_wait_cnt;
    assign w_in_err = (r_state == S_ERR);
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT == 0);
    assign w_in_err = 1'b0;
`endif

    always_comb begin
        ForwardAE = 2'b00;
        if (RegWriteM && RdM != 5'd0 && RdM == Rs1E)      ForwardAE = 2'b10;
        else if (RegWriteW && RdW != 5'd0 && RdW == Rs1E) ForwardAE = 2'b01;
        ForwardBE = 2'b00;
        if (RegWriteM && RdM != 5'd0 && RdM == Rs2E)      ForwardBE = 2'b10;
        else if (RegWriteW && RdW != 5'd0 && RdW == Rs2E) ForwardBE = 2'b01;
    end

    assign w_lw_stall  = ResultSrcE0 && (RdE != 5'd0) && (RdE == Rs1D || RdE == Rs2D);
    assign w_mem_stall = (r_state == S_IDLE && MemReqM) || (r_state == S_WAIT && !mem_ack);
    assign mem_req     = (r_state == S_IDLE && MemReqM) || (r_state == S_WAIT);
    // A memory wait (or the ERR lockup) freezes the whole front of the pipe and
    // drops the W-stage write; branch flushes are deferred until the wait clears.
    assign w_hold      = w_mem_stall || w_in_err;

    always_comb begin
        if (w_hold) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
            FlushD = 1'b0;
            FlushE = 1'b0;
        end else begin
            StallF = w_lw_stall;
            StallD = w_lw_stall;
            StallE = 1'b0;
            StallM = 1'b0;
            FlushW = 1'b0;
            FlushD = PCSrcE;
            FlushE = w_lw_stall || PCSrcE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_stall_cnt <= 16'd0;
            r_timeout   <= 1'b0;
`ifdef HAZARD_TIMEOUT_EN
            r_wait_cnt  <= '0;
`endif
        end else begin
            if (StallF && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
            case (r_state)
                S_IDLE: begin
                    if (MemReqM) begin
                        r_state <= S_WAIT;
`ifdef HAZARD_TIMEOUT_EN
                        r_wait_cnt <= '0;
`endif
                    end
                end
                S_WAIT: begin
                    if (mem_ack) begin
                        r_state <= S_IDLE;
                    end
`ifdef HAZARD_TIMEOUT_EN
                    else if (r_wait_cnt == CW'(TIMEOUT - 1)) begin
                        r_state   <= S_ERR;
                        r_timeout <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CW'(1);
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    assign stall_cnt   = r_stall_cnt;
    assign mem_timeout = r_timeout;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus random traffic
// compared each cycle against a behavioural model of the hazard rules.
module tb_pipeline_hazard_ctrl;
    localparam int TIMEOUT = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [4:0] Rs1D = '0, Rs2D = '0, Rs1E = '0, Rs2E = '0, RdE = '0, RdM = '0, RdW = '0;
    logic ResultSrcE0 = 0, RegWriteM = 0, RegWriteW = 0, PCSrcE = 0, MemReqM = 0, mem_ack = 0;
    logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_req, mem_timeout;
    logic [1:0] ForwardAE, ForwardBE, dbg_state;
    logic [15:0] stall_cnt;

    int n_total = 0;
    int n_bad = 0;

    // model state: outstanding memory op, sticky error, WAIT cycles seen, stall count
    bit m_busy = 0, m_err = 0;
    int m_wait = 0, m_cnt = 0;

    pipeline_hazard_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .ResultSrcE0(ResultSrcE0), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .PCSrcE(PCSrcE), .MemReqM(MemReqM), .mem_ack(mem_ack),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .mem_req(mem_req),
        .stall_cnt(stall_cnt), .mem_timeout(mem_timeout), .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] fwd(input logic [4:0] src);
        if (RegWriteM && RdM != 0 && RdM == src) return 2'b10;
        if (RegWriteW && RdW != 0 && RdW == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit exp_lw();
        return ResultSrcE0 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    endfunction

    function automatic bit exp_hold();
        return m_err || (!m_busy && MemReqM) || (m_busy && !mem_ack);
    endfunction

    function automatic bit exp_stallf();
        return exp_hold() || exp_lw();
    endfunction

    // compare every output with the model at the negedge of the current cycle
    task automatic sample();
        bit h, lw;
        @(negedge clk);
        h  = exp_hold();
        lw = exp_lw();
        check_eq("StallF", StallF, h | lw);
        check_eq("StallD", StallD, h | lw);
        check_eq("StallE", StallE, h);
        check_eq("StallM", StallM, h);
        check_eq("FlushW", FlushW, h);
        check_eq("FlushD", FlushD, !h && PCSrcE);
        check_eq("FlushE", FlushE, !h && (PCSrcE || lw));
        check_eq("ForwardAE", ForwardAE, fwd(Rs1E));
        check_eq("ForwardBE", ForwardBE, fwd(Rs2E));
        check_eq("mem_req", mem_req, (!m_busy && !m_err && MemReqM) || m_busy);
        check_eq("stall_cnt", stall_cnt, m_cnt[15:0]);
        check_eq("mem_timeout", mem_timeout, m_err);
    endtask

    // advance the model by one clock and move to just after the edge
    task automatic advance();
        if (rst) begin
            m_busy = 0; m_err = 0; m_wait = 0; m_cnt = 0;
        end else begin
            if (exp_stallf() && m_cnt < 65535) m_cnt++;
            if (!m_busy && !m_err && MemReqM) begin
                m_busy = 1; m_wait = 0;
            end else if (m_busy && mem_ack) begin
                m_busy = 0;
            end else if (m_busy) begin
`ifdef HAZARD_TIMEOUT_EN
                m_wait++;
                if (m_wait == TIMEOUT) begin m_busy = 0; m_err = 1; end
`endif
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        sample();
        advance();
    endtask

    task automatic clear_inputs();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        ResultSrcE0 = 0; RegWriteM = 0; RegWriteW = 0; PCSrcE = 0; MemReqM = 0; mem_ack = 0;
    endtask

    function automatic logic [4:0] rnd_reg();
        return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
    endfunction

    task automatic drive_random();
        Rs1D = rnd_reg(); Rs2D = rnd_reg(); Rs1E = rnd_reg(); Rs2E = rnd_reg();
        RdE = rnd_reg(); RdM = rnd_reg(); RdW = rnd_reg();
        ResultSrcE0 = 1'($urandom_range(0, 1));
        RegWriteM   = 1'($urandom_range(0, 1));
        RegWriteW   = 1'($urandom_range(0, 1));
        PCSrcE      = ($urandom_range(0, 4) == 0);
        MemReqM     = ($urandom_range(0, 3) == 0);
        mem_ack     = ($urandom_range(0, 2) == 0);
        rst         = ($urandom_range(0, 199) == 0);
    endtask

    initial begin
        int n_req, n_stall;
        // reset
        rst = 1;
        advance();
        advance();
        rst = 0;
        sample();
        check_eq("reset_stall_cnt", stall_cnt, 16'd0);
        check_eq("reset_mem_req", mem_req, 1'b0);
        advance();

        // load-use stall
        RdE = 5; ResultSrcE0 = 1; Rs1D = 5;
        sample();
        check_eq("lw_StallF", StallF, 1'b1);
        check_eq("lw_FlushE", FlushE, 1'b1);
        advance();
        clear_inputs();
        sample();
        check_eq("lw_cnt_one", stall_cnt, 16'd1);
        check_eq("lw_gone", StallF, 1'b0);
        advance();
        RdE = 0; ResultSrcE0 = 1; Rs1D = 0;
        sample();
        check_eq("lw_rd0_nostall", StallF, 1'b0);
        advance();
        clear_inputs();

        // forwarding priority
        RdM = 3; RdW = 3; RegWriteM = 1; RegWriteW = 1; Rs1E = 3;
        sample();
        check_eq("fwd_mem", ForwardAE, 2'b10);
        advance();
        RegWriteM = 0;
        sample();
        check_eq("fwd_wb", ForwardAE, 2'b01);
        advance();
        clear_inputs();

        // memory op acknowledged on the 4th cycle
        n_req = 0; n_stall = 0;
        for (int i = 1; i <= 5; i++) begin
            MemReqM = (i == 1);
            mem_ack = (i == 4);
            sample();
            n_req += int'(mem_req);
            n_stall += int'(StallM);
            advance();
        end
        check_eq("mem4_req_cycles", 16'(n_req), 16'd4);
        check_eq("mem4_stall_cycles", 16'(n_stall), 16'd3);
        clear_inputs();

        // branch during WAIT is held back until ack
        MemReqM = 1; cyc(); MemReqM = 0;
        PCSrcE = 1;
        sample();
        check_eq("br_wait_FlushD", FlushD, 1'b0);
        check_eq("br_wait_FlushE", FlushE, 1'b0);
        advance();
        mem_ack = 1; cyc(); mem_ack = 0;
        sample();
        check_eq("br_after_FlushD", FlushD, 1'b1);
        check_eq("br_after_FlushE", FlushE, 1'b1);
        advance();
        clear_inputs();

        // load-use and branch together
        RdE = 7; ResultSrcE0 = 1; Rs2D = 7; PCSrcE = 1;
        sample();
        check_eq("both_StallD", StallD, 1'b1);
        check_eq("both_FlushD", FlushD, 1'b1);
        check_eq("both_FlushE", FlushE, 1'b1);
        advance();
        clear_inputs();

        // reset in the middle of a wait
        MemReqM = 1; cyc(); MemReqM = 0; cyc();
        rst = 1; cyc(); rst = 0;
        sample();
        check_eq("rst_wait_mem_req", mem_req, 1'b0);
        advance();

        // no ack at all
        MemReqM = 1; cyc(); MemReqM = 0;
        for (int i = 0; i < TIMEOUT + 4; i++) cyc();
        sample();
`ifdef HAZARD_TIMEOUT_EN
        check_eq("to_mem_timeout", mem_timeout, 1'b1);
        check_eq("to_stall_held", StallM, 1'b1);
`else
        check_eq("to_still_wait", mem_req, 1'b1);
        check_eq("to_no_timeout", mem_timeout, 1'b0);
`endif
        advance();
        rst = 1; cyc(); rst = 0;
        sample();
        check_eq("to_rst_timeout", mem_timeout, 1'b0);
        check_eq("to_rst_stall", StallF, 1'b0);
        advance();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            drive_random();
            cyc();
        end
        clear_inputs();
        rst = 1; cyc(); rst = 0;

        // continuous load-use stall until the counter saturates
        RdE = 9; ResultSrcE0 = 1; Rs1D = 9;
        for (int i = 0; i < 65540; i++) cyc();
        sample();
        check_eq("sat_cnt", stall_cnt, 16'hFFFF);
        advance();
        cyc();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have ports: clk in 1, rising-edge clock; rst in 1, synchronous active-high reset.
REQ-002 SHALL have inputs: Rs1D, Rs2D in 5, D-stage sources; Rs1E, Rs2E, RdE in 5, E-stage sources and destination; RdM, RdW in 5, M/W destinations.
REQ-003 SHALL have inputs: ResultSrcE0 in 1, load in E; RegWriteM, RegWriteW in 1; PCSrcE in 1, taken branch/jump in E; MemReqM in 1, load/store in M; mem_ack in 1, data-memory completion.
REQ-004 SHALL have outputs: StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW out 1; ForwardAE, ForwardBE out 2; mem_req out 1; stall_cnt out 16, saturating stall-cycle count; mem_timeout out 1.
REQ-005 SHALL have parameter TIMEOUT, default 15, WAIT-cycle limit.

Function
REQ-006 Forwarding SHALL be combinational: ForwardAE=10 if RegWriteM and RdM!=0 and RdM==Rs1E; else 01 if RegWriteW and RdW!=0 and RdW==Rs1E; else 00. ForwardBE is the same using Rs2E.
REQ-007 lwStall SHALL equal ResultSrcE0 and RdE!=0 and (RdE==Rs1D or RdE==Rs2D).
REQ-008 FSM states SHALL be IDLE, WAIT and ERR; ERR exists only per REQ-018.
REQ-009 memStall SHALL equal (IDLE and MemReqM) or (WAIT and not mem_ack).
REQ-010 mem_req SHALL equal (IDLE and MemReqM) or WAIT.
REQ-011 Transitions: IDLE->WAIT on MemReqM; WAIT->IDLE on mem_ack; all other cases hold state.
REQ-012 When memStall=1, StallF, StallD, StallE, StallM and FlushW SHALL be 1, and FlushD and FlushE SHALL be 0.
REQ-013 When memStall=0: StallF=StallD=lwStall; FlushE=lwStall or PCSrcE; FlushD=PCSrcE; StallE=StallM=FlushW=0.
REQ-014 Simultaneous lwStall and PCSrcE with memStall=0 SHALL give StallF=StallD=1 and FlushD=FlushE=1.
REQ-015 mem_ack in IDLE SHALL be ignored; minimum memory-op latency SHALL be 2 cycles (IDLE cycle plus WAIT cycle with mem_ack).
REQ-016 stall_cnt SHALL increment on each cycle with StallF=1 and saturate at 16'hFFFF without wrapping.

Reset
REQ-017 rst SHALL force, at the next clk edge: state IDLE, stall_cnt 0, wait counter 0, mem_timeout 0; combinational outputs follow from IDLE; reset mid-WAIT SHALL drop mem_req the following cycle.

Configuration
REQ-018 Macro HAZARD_TIMEOUT_EN:
- Defined: a wait counter SHALL count cycles in WAIT. When TIMEOUT cycles elapse without mem_ack, the FSM SHALL go to ERR with mem_timeout=1 (sticky until rst) and all Stall* outputs held 1; ERR exits only on rst.
- Undefined: there SHALL be no counter and no ERR state, mem_timeout SHALL be tied to 0, and WAIT SHALL be held indefinitely.

Verification
REQ-019 RdE=5, ResultSrcE0=1, Rs1D=5 SHALL give StallF=StallD=FlushE=1 for 1 cycle and stall_cnt=1. RdE=0 in the same setup SHALL give no stall.
REQ-020 RdM=3, RdW=3, both RegWrite=1, Rs1E=3 SHALL give ForwardAE=10. With RegWriteM=0 it SHALL give ForwardAE=01.
REQ-021 MemReqM=1 with mem_ack on the 4th cycle SHALL give mem_req high for 4 cycles, StallF..StallM high for 3 cycles, and return to IDLE.
REQ-022 PCSrcE=1 during WAIT SHALL keep FlushD=FlushE=0 until ack. On the cycle after ack with PCSrcE=1 it SHALL give FlushD=FlushE=1.
REQ-023 With HAZARD_TIMEOUT_EN defined and TIMEOUT=15, no mem_ack SHALL give mem_timeout=1 after 15 WAIT cycles and stalls held. rst SHALL clear both. With the macro undefined, the same stimulus SHALL leave the FSM in WAIT.
REQ-024 Forcing stall_cnt near 16'hFFFF with continuous stalls SHALL make it saturate at 16'hFFFF.
